// File: rtl/ddr5_phy_cmd_scheduler.sv
// ddr5_phy_cmd_scheduler
//
// Purpose: arbitrates between a mode-register-write (MRW) requester and a
// write (WR) requester and serialises each granted command into its two DDR5
// command cycles on the DFI command bus. After the second cycle, a per-command
// idle gap of deselect cycles is inserted before the next grant.
//
// Ports:
//   clk_i          clock, single domain
//   rst_i          synchronous reset, active-high
//   enable_i       0 freezes all state and outputs; ready outputs forced 0
//   mrw_valid_i    MRW request pending
//   mrw_ready_o    MRW grant (combinational)
//   mrw_addr_i     mode register address (MRA)
//   mrw_op_i       mode register operand (OP)
//   wr_valid_i     WR request pending
//   wr_ready_o     WR grant (combinational, MRW has priority)
//   wr_rank_i      target rank index
//   wr_bl_def_i    1: default BL16 (CA5=1)
//   wr_bank_i      CA[13:6] of the WR 1st cycle
//   wr_col_i       full CA of the WR 2nd cycle
//   dfi_address_o  registered command/address bus
//   dfi_cs_o       registered chip selects, active-low
//   busy_o         registered, 1 when not idle

module ddr5_phy_cmd_scheduler #(
    parameter int unsigned pNUM_RANK = 1,
    parameter int unsigned pMRW_GAP  = 8,
    parameter int unsigned pWR_GAP   = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         enable_i,
    input  logic                                         mrw_valid_i,
    output logic                                         mrw_ready_o,
    input  logic [7:0]                                   mrw_addr_i,
    input  logic [7:0]                                   mrw_op_i,
    input  logic                                         wr_valid_i,
    output logic                                         wr_ready_o,
    input  logic [((pNUM_RANK > 1) ? $clog2(pNUM_RANK) : 1)-1:0] wr_rank_i,
    input  logic                                         wr_bl_def_i,
    input  logic [7:0]                                   wr_bank_i,
    input  logic [13:0]                                  wr_col_i,
    output logic [13:0]                                  dfi_address_o,
    output logic [pNUM_RANK-1:0]                         dfi_cs_o,
    output logic                                         busy_o
);

    localparam int unsigned pRW = (pNUM_RANK > 1) ? $clog2(pNUM_RANK) : 1;

    localparam logic [3:0] LP_MRW_GAP = 4'(pMRW_GAP);
    localparam logic [3:0] LP_WR_GAP  = 4'(pWR_GAP);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd2 = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e               r_state;
    logic [3:0]           r_gap_cnt;
    logic [3:0]           r_gap_sel;
    logic [13:0]          r_ca2;
    logic [13:0]          r_address;
    logic [pNUM_RANK-1:0] r_cs;
    logic                 r_busy;

    logic                 w_idle;
    logic [13:0]          w_mrw_ca1;
    logic [13:0]          w_wr_ca1;
    logic [pNUM_RANK-1:0] w_wr_cs;

    always_comb begin
        w_idle      = (r_state == StIdle);
        mrw_ready_o = enable_i & w_idle & mrw_valid_i;
        wr_ready_o  = enable_i & w_idle & wr_valid_i & ~mrw_valid_i;

        w_mrw_ca1 = {1'b0, mrw_addr_i, 5'b00101};
        w_wr_ca1  = {wr_bank_i, wr_bl_def_i, 5'b01101};

        // Out-of-range rank matches no bit, so every chip select stays high.
        w_wr_cs = '1;
        for (int i = 0; i < int'(pNUM_RANK); i++) begin
            w_wr_cs[i] = (wr_rank_i != pRW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_gap_cnt <= 4'd0;
            r_gap_sel <= 4'd0;
            r_ca2     <= 14'h0;
            r_address <= 14'h0;
            r_cs      <= '1;
            r_busy    <= 1'b0;
        end else if (enable_i) begin
            unique case (r_state)
                StIdle: begin
                    if (mrw_ready_o) begin
                        r_address <= w_mrw_ca1;
                        r_cs      <= '0;
                        // CA10 must be 0 on the MRW 2nd cycle, hence zero upper bits.
                        r_ca2     <= {6'b0, mrw_op_i};
                        r_gap_sel <= LP_MRW_GAP;
                        r_state   <= StCmd2;
                        r_busy    <= 1'b1;
                    end else if (wr_ready_o) begin
                        r_address <= w_wr_ca1;
                        r_cs      <= w_wr_cs;
                        r_ca2     <= wr_col_i;
                        r_gap_sel <= LP_WR_GAP;
                        r_state   <= StCmd2;
                        r_busy    <= 1'b1;
                    end else begin
                        r_address <= 14'h0;
                        r_cs      <= '1;
                    end
                end
                StCmd2: begin
                    r_address <= r_ca2;
                    r_cs      <= '1;
                    r_gap_cnt <= r_gap_sel;
                    if (r_gap_sel == 4'd0) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= StGap;
                        r_busy  <= 1'b1;
                    end
                end
                StGap: begin
                    r_address <= 14'h0;
                    r_cs      <= '1;
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                    // Leaving at count 1 lets the next grant land gap+2 edges after the last.
                    if (r_gap_cnt <= 4'd1) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_address <= 14'h0;
                    r_cs      <= '1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dfi_address_o = r_address;
    assign dfi_cs_o      = r_cs;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_ddr5_phy_cmd_scheduler.sv
// Testbench for ddr5_phy_cmd_scheduler (default parameters: 1 rank,
// MRW gap 8, WR gap 2). Each vector is one clock cycle: inputs are driven
// after the falling edge, ready outputs are checked before the rising edge,
// registered outputs are checked 1 time unit after it.

module tb_ddr5_phy_cmd_scheduler;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mrw_valid;
    logic        mrw_ready;
    logic [7:0]  mrw_addr;
    logic [7:0]  mrw_op;
    logic        wr_valid;
    logic        wr_ready;
    logic [0:0]  wr_rank;
    logic        wr_bl_def;
    logic [7:0]  wr_bank;
    logic [13:0] wr_col;
    logic [13:0] dfi_address;
    logic [0:0]  dfi_cs;
    logic        busy;

    int n_checks;
    int n_errors;

    ddr5_phy_cmd_scheduler #(
        .pNUM_RANK (1),
        .pMRW_GAP  (8),
        .pWR_GAP   (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .mrw_valid_i   (mrw_valid),
        .mrw_ready_o   (mrw_ready),
        .mrw_addr_i    (mrw_addr),
        .mrw_op_i      (mrw_op),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_rank_i     (wr_rank),
        .wr_bl_def_i   (wr_bl_def),
        .wr_bank_i     (wr_bank),
        .wr_col_i      (wr_col),
        .dfi_address_o (dfi_address),
        .dfi_cs_o      (dfi_cs),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        mv;
        logic [7:0]  maddr;
        logic [7:0]  mop;
        logic        wv;
        logic [0:0]  wrank;
        logic        wbl;
        logic [7:0]  wbank;
        logic [13:0] wcol;
        logic        exp_mrdy;
        logic        exp_wrdy;
        logic [13:0] exp_addr;
        logic [0:0]  exp_cs;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic mv,
                                input logic [7:0] ma, input logic [7:0] mo,
                                input logic wv, input logic [0:0] wrk, input logic wbl,
                                input logic [7:0] wbk, input logic [13:0] wcl,
                                input logic xm, input logic xw, input logic [13:0] xa,
                                input logic [0:0] xc, input logic xb);
        vec_t v;
        v.rst = r;  v.en = e;  v.mv = mv;  v.maddr = ma;  v.mop = mo;
        v.wv = wv;  v.wrank = wrk;  v.wbl = wbl;  v.wbank = wbk;  v.wcol = wcl;
        v.exp_mrdy = xm;  v.exp_wrdy = xw;  v.exp_addr = xa;  v.exp_cs = xc;
        v.exp_busy = xb;
        return v;
    endfunction

    task automatic check1(input string name, input int idx, input logic [13:0] act,
                          input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst       = v.rst;
        en        = v.en;
        mrw_valid = v.mv;
        mrw_addr  = v.maddr;
        mrw_op    = v.mop;
        wr_valid  = v.wv;
        wr_rank   = v.wrank;
        wr_bl_def = v.wbl;
        wr_bank   = v.wbank;
        wr_col    = v.wcol;
        #1;
        check1("mrw_ready", idx, 14'(mrw_ready), 14'(v.exp_mrdy));
        check1("wr_ready", idx, 14'(wr_ready), 14'(v.exp_wrdy));
        @(posedge clk);
        #1;
        check1("dfi_address", idx, dfi_address, v.exp_addr);
        check1("dfi_cs", idx, 14'(dfi_cs), 14'(v.exp_cs));
        check1("busy", idx, 14'(busy), 14'(v.exp_busy));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        en        = 1'b1;
        mrw_valid = 1'b0;
        mrw_addr  = 8'h0;
        mrw_op    = 8'h0;
        wr_valid  = 1'b0;
        wr_rank   = 1'b0;
        wr_bl_def = 1'b0;
        wr_bank   = 8'h0;
        wr_col    = 14'h0;

        // Reset for two cycles.
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                              0, 0, 14'h0000, 1, 0));
        // MRW MRA=8, OP=0x18: grant at edge k.
        vecs.push_back(mk(0, 1, 1, 8'h08, 8'h18, 0, 0, 0, 8'h00, 14'h0,
                          1, 0, 14'h0105, 0, 1));
        // 2nd cycle, requester dropped valid.
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                          0, 0, 14'h0018, 1, 1));
        // Both requesters pending during the 8-cycle gap: no grant.
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 1, 1, 8'h33, 8'h44, 1, 0, 0, 8'hA5, 14'h1234,
                              0, 0, 14'h0000, 1, 1));
        // Last gap edge returns to idle.
        vecs.push_back(mk(0, 1, 1, 8'h33, 8'h44, 1, 0, 0, 8'hA5, 14'h1234,
                          0, 0, 14'h0000, 1, 0));
        // Edge k+10: MRW wins over simultaneous WR.
        vecs.push_back(mk(0, 1, 1, 8'h33, 8'h44, 1, 0, 0, 8'hA5, 14'h1234,
                          1, 0, 14'h0665, 0, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'hA5, 14'h1234,
                          0, 0, 14'h0044, 1, 1));
        // WR kept waiting through the MRW gap.
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'hA5, 14'h1234,
                              0, 0, 14'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'hA5, 14'h1234,
                          0, 0, 14'h0000, 1, 0));
        // WR granted 10 edges after the MRW grant.
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'hA5, 14'h1234,
                          0, 1, 14'h294D, 0, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                          0, 0, 14'h1234, 1, 1));
        // WR gap of 2; rank 1 is out of range for a single-rank build.
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h3C, 14'h2ABC,
                          0, 0, 14'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h3C, 14'h2ABC,
                          0, 0, 14'h0000, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h3C, 14'h2ABC,
                          0, 1, 14'h0F2D, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                          0, 0, 14'h2ABC, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                          0, 0, 14'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                          0, 0, 14'h0000, 1, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Enable low for 3 cycles while in CMD2: everything frozen.
        apply(mk(0, 1, 1, 8'h01, 8'h5A, 0, 0, 0, 8'h00, 14'h0,
                 1, 0, 14'h0025, 0, 1), 100);
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, 1, 8'h77, 8'h77, 1, 0, 0, 8'h00, 14'h0,
                     0, 0, 14'h0025, 0, 1), 101 + i);
        apply(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                 0, 0, 14'h005A, 1, 1), 104);
        apply(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                 0, 0, 14'h0000, 1, 1), 105);

        // Reset while in GAP, then immediate WR grant.
        apply(mk(1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                 0, 0, 14'h0000, 1, 0), 200);
        apply(mk(0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 8'h01, 14'h0007,
                 0, 1, 14'h006D, 0, 1), 201);
        // Reset while in CMD2 abandons the 2nd cycle, then immediate MRW grant.
        apply(mk(1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                 0, 0, 14'h0000, 1, 0), 202);
        apply(mk(0, 1, 1, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                 1, 0, 14'h1FE5, 0, 1), 203);
        apply(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 14'h0,
                 0, 0, 14'h0000, 1, 1), 204);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
